// File: rtl/diffusion_pkg.sv
// diffusion_pkg: AES state types and GF(2^8) helpers (xtime, gmul3) shared by the diffusion core
package diffusion_pkg;
  typedef logic [7:0] byte_t;
  typedef byte_t [3:0][3:0] state_t;
  localparam byte_t AES_POLY = 8'h1B;
  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction
  function automatic byte_t gmul3(input byte_t a);
    return xtime(a) ^ a;
  endfunction
endpackage

// File: rtl/diffusion_mix_column.sv
// mix_column: combinational AES MixColumns of one column; col_in[r] -> col_out[r], r = row 0..3
module mix_column
  import diffusion_pkg::*;
(
  input  byte_t [3:0] col_in,
  output byte_t [3:0] col_out
);
  assign col_out[0] = xtime(col_in[0]) ^ gmul3(col_in[1]) ^ col_in[2] ^ col_in[3];
  assign col_out[1] = col_in[0] ^ xtime(col_in[1]) ^ gmul3(col_in[2]) ^ col_in[3];
  assign col_out[2] = col_in[0] ^ col_in[1] ^ xtime(col_in[2]) ^ gmul3(col_in[3]);
  assign col_out[3] = gmul3(col_in[0]) ^ col_in[1] ^ col_in[2] ^ xtime(col_in[3]);
endmodule

// File: rtl/diffusion_core.sv
// diffusion_core: registered AES ShiftRows+MixColumns, 1-cycle latency, async active-low reset
// Ports: clk, rst_n, in_valid/diffusion_in (state[r][c]) in; out_valid/diffusion_out out;
// srows_out (ShiftRows-only result) exists only when DIFFUSION_SROWS_OUT_EN is defined.
module diffusion_core
  import diffusion_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  state_t diffusion_in,
`ifdef DIFFUSION_SROWS_OUT_EN
  output state_t srows_out,
`endif
  output logic   out_valid,
  output state_t diffusion_out
);
  state_t srows;
  state_t mixed;
  for (genvar c = 0; c < 4; c++) begin : g_col
    byte_t [3:0] col_out;
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign srows[r][c] = diffusion_in[r][(c + r) % 4];
      assign mixed[r][c] = col_out[r];
    end
    mix_column u_mix (
      .col_in ({srows[3][c], srows[2][c], srows[1][c], srows[0][c]}),
      .col_out(col_out)
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid     <= 1'b0;
      diffusion_out <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) diffusion_out <= mixed;
    end
`ifdef DIFFUSION_SROWS_OUT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) srows_out <= '0;
    else if (in_valid) srows_out <= srows;
`endif
endmodule

// File: tb/tb_diffusion_core.sv
// tb_diffusion_core: directed vectors plus a matrix-level GF(2^8) reference model for diffusion_core
module tb_diffusion_core;
  import diffusion_pkg::*;
  logic   clk = 0;
  logic   rst_n = 0;
  logic   in_valid = 0;
  state_t din = '0;
  logic   out_valid;
  state_t dout;
  int checks = 0;
  int errors = 0;
`ifdef DIFFUSION_SROWS_OUT_EN
  state_t sr_out;
`endif
  diffusion_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .diffusion_in (din),
`ifdef DIFFUSION_SROWS_OUT_EN
    .srows_out    (sr_out),
`endif
    .out_valid    (out_valid),
    .diffusion_out(dout)
  );
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction
  function automatic state_t ref_shift(input state_t s);
    state_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = s[r][(c + r) % 4];
    return t;
  endfunction
  function automatic state_t ref_diffuse(input state_t s);
    logic [7:0] m [4] = '{8'd2, 8'd3, 8'd1, 8'd1};
    state_t t = ref_shift(s);
    state_t o = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) o[i][c] ^= gf_mul(m[(j - i + 4) % 4], t[j][c]);
    return o;
  endfunction

  logic   m_valid;
  state_t m_out, m_sr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid = 0; m_out = '0; m_sr = '0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin m_out = ref_diffuse(din); m_sr = ref_shift(din); end
    end

  always @(negedge clk) begin
    checks++;
    if (out_valid !== m_valid || dout !== m_out) begin
      errors++;
      $display("FAIL model_cmp t=%0t: valid %b out %h, expected valid %b out %h", $time, out_valid, dout, m_valid, m_out);
    end
`ifdef DIFFUSION_SROWS_OUT_EN
    checks++;
    if (sr_out !== m_sr) begin
      errors++;
      $display("FAIL model_srows t=%0t: got %h expected %h", $time, sr_out, m_sr);
    end
`endif
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic apply(input state_t s, input logic v);
    @(posedge clk); #1;
    din = s; in_valid = v;
  endtask
  task automatic chk_col0(input string name, input logic [7:0] e0, e1, e2, e3);
    chk({name, "_valid"}, 128'(out_valid), 128'(1));
    chk({name, "_col0"}, {dout[3][0], dout[2][0], dout[1][0], dout[0][0]}, {e3, e2, e1, e0});
  endtask
  function automatic state_t diag(input logic [7:0] a, b, c, d);
    state_t s = '0;
    s[0][0] = a; s[1][1] = b; s[2][2] = c; s[3][3] = d;
    return s;
  endfunction

  state_t ones, rowpat, fips1, fips2, rs;
  initial begin
    for (int r = 0; r < 4; r++) begin
      rowpat[r] = {8'd1, 8'd2, 8'd3, 8'd4};
      for (int c = 0; c < 4; c++) ones[r][c] = 8'h01;
    end
    fips1 = diag(8'hdb, 8'h13, 8'h53, 8'h45);
    fips2 = diag(8'hd4, 8'hbf, 8'h5d, 8'h30);
    #12 rst_n = 1;
    apply(ones, 1);
    apply(rowpat, 1);
    chk("uniform_valid", 128'(out_valid), 128'(1));
    chk("uniform_out", dout, ones);
    apply(fips1, 1);
    chk_col0("rowpat", 8'h0e, 8'h05, 8'h00, 8'h0f);
`ifdef DIFFUSION_SROWS_OUT_EN
    chk("rowpat_srows_r1", sr_out[1], {8'd4, 8'd1, 8'd2, 8'd3});
`endif
    apply(fips2, 1);
    chk_col0("fips1", 8'h8e, 8'h4d, 8'ha1, 8'hbc);
    apply('0, 0);
    chk_col0("fips2", 8'h04, 8'h66, 8'h81, 8'he5);
    apply('0, 0);
    chk("stream_valid_low", 128'(out_valid), 128'(0));
    chk("stream_hold", {dout[3][0], dout[2][0], dout[1][0], dout[0][0]}, {8'he5, 8'h81, 8'h66, 8'h04});
    apply(rowpat, 1);
    apply(fips1, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", 128'(out_valid), 128'(0));
    chk("async_rst_out", dout, '0);
    din = '0; in_valid = 0;
    @(posedge clk); #1;
    chk("rst_hold_out", dout, '0);
    @(negedge clk); #1 rst_n = 1;
    apply(fips2, 1);
    chk("post_rst_idle_valid", 128'(out_valid), 128'(0));
    apply('0, 0);
    chk_col0("post_rst_fips2", 8'h04, 8'h66, 8'h81, 8'he5);
    for (int k = 0; k < 12; k++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) rs[r][c] = 8'($urandom);
      apply(rs, 1'($urandom_range(0, 3) != 0));
    end
    apply('0, 0);
    apply('0, 0);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
